// File: rtl/branch_pkg.sv
// Shared types and constants for the branch unit.
//   br_op_e : branch operation encoding (B, BL, BX, BLX)
//   cond_e  : condition code encoding
//   state_e : branch FSM states
//   FLAG_*  : bit positions of Z/N/V inside the ALU flag word / status register
package branch_pkg;

  typedef enum logic [1:0] {
    OpB   = 2'b00,
    OpBl  = 2'b01,
    OpBx  = 2'b10,
    OpBlx = 2'b11
  } br_op_e;

  typedef enum logic [2:0] {
    CondAl = 3'b000,
    CondEq = 3'b001,
    CondNe = 3'b010,
    CondLt = 3'b011,
    CondLe = 3'b100,
    CondGe = 3'b101,
    CondGt = 3'b110,
    CondMi = 3'b111
  } cond_e;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StExec = 2'b01,
    StDone = 2'b10
  } state_e;

  // Same ordering as the ALU flag_out bus.
  localparam int unsigned FLAG_Z = 0;
  localparam int unsigned FLAG_N = 1;
  localparam int unsigned FLAG_V = 2;

  // Call-type branches write the link register.
  function automatic logic is_link(br_op_e op);
    return (op == OpBl) || (op == OpBlx);
  endfunction

  // Register-indirect branches take their target from rd_val.
  function automatic logic is_indirect(br_op_e op);
    return (op == OpBx) || (op == OpBlx);
  endfunction

endpackage

// File: rtl/cond_eval.sv
// Combinational branch condition evaluator.
//   status  in  3  registered flags {V,N,Z}
//   cond    in  3  condition code
//   cond_ok out 1  condition holds
// Build option: BRANCH_COND_EXT_EN enables GE/GT/MI on codes 101..111;
// without it those codes never pass.
module cond_eval
  import branch_pkg::*;
(
  input  logic [2:0] status,
  input  logic [2:0] cond,
  output logic       cond_ok
);

  logic z, n, v;

  assign z = status[FLAG_Z];
  assign n = status[FLAG_N];
  assign v = status[FLAG_V];

  always_comb begin
    cond_ok = 1'b0;
    case (cond_e'(cond))
      CondAl: cond_ok = 1'b1;
      CondEq: cond_ok = z;
      CondNe: cond_ok = ~z;
      CondLt: cond_ok = n ^ v;
      CondLe: cond_ok = (n ^ v) | z;
`ifdef BRANCH_COND_EXT_EN
      CondGe: cond_ok = ~(n ^ v);
      CondGt: cond_ok = ~(n ^ v) & ~z;
      CondMi: cond_ok = n;
`endif
      default: cond_ok = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_unit.sv
// Branch unit: status flag register, branch condition evaluation and program counter.
//   clk, rst_n          clock / async active-low reset
//   flag_in, flag_load  ALU flags {V,N,Z} and their capture strobe
//   pc_inc              sequential advance (IDLE only, loses to an accept)
//   br_valid/br_ready   branch request handshake (ready only in IDLE)
//   br_op, cond         operation (B/BL/BX/BLX) and condition code (B only)
//   offset              signed PC-relative offset
//   rd_val              register value for BX/BLX targets
//   pc, status          current PC and registered flags
//   lr_we, lr_data      link-register write (BL/BLX) during DONE
//   done, taken         completion pulse and taken indication
// Build option: BRANCH_COND_EXT_EN (see cond_eval) adds conditions GE/GT/MI.
// Every branch takes IDLE -> EXEC -> DONE; the PC is updated on the EXEC edge.
module branch_unit
  import branch_pkg::*;
#(
  parameter int unsigned     PC_W     = 9,
  parameter int unsigned     IMM_W    = 8,
  parameter int unsigned     DATA_W   = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [2:0]        flag_in,
  input  logic              flag_load,
  input  logic              pc_inc,
  input  logic              br_valid,
  output logic              br_ready,
  input  logic [1:0]        br_op,
  input  logic [2:0]        cond,
  input  logic [IMM_W-1:0]  offset,
  input  logic [DATA_W-1:0] rd_val,
  output logic [PC_W-1:0]   pc,
  output logic [2:0]        status,
  output logic              lr_we,
  output logic [DATA_W-1:0] lr_data,
  output logic              done,
  output logic              taken
);

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [2:0]      status_q;
  br_op_e          op_q;
  logic [PC_W-1:0] rd_q, ret_q, tgt_q;
  logic            taken_q;

  logic            accept;
  logic            cond_ok;
  logic [PC_W-1:0] off_ext;
  logic [PC_W-1:0] ret_d, tgt_d;
  logic            taken_d;
  logic            unused_rd;

  // Only the low PC_W bits of a register target are meaningful.
  assign unused_rd = ^rd_val[DATA_W-1:PC_W];

  assign br_ready = (state_q == StIdle);
  assign accept   = br_valid & br_ready;

  // Condition is judged on the status held before any same-edge flag_load.
  cond_eval u_cond_eval (
    .status  (status_q),
    .cond    (cond),
    .cond_ok (cond_ok)
  );

  // Sign-extending size cast; target arithmetic wraps modulo 2^PC_W.
  assign off_ext = PC_W'($signed(offset));
  assign ret_d   = pc_q + PC_W'(1);
  assign tgt_d   = ret_d + off_ext;
  assign taken_d = (br_op_e'(br_op) != OpB) | cond_ok;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StExec;
        end else if (pc_inc) begin
          pc_d = pc_q + PC_W'(1);
        end
      end
      StExec: begin
        state_d = StDone;
        if (!taken_q) begin
          pc_d = ret_q;
        end else if (is_indirect(op_q)) begin
          pc_d = rd_q;
        end else begin
          pc_d = tgt_q;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  // Status register is independent of the branch FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      status_q <= '0;
    end else if (flag_load) begin
      status_q <= flag_in;
    end
  end

  // Request snapshot taken on the accept edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q    <= OpB;
      rd_q    <= '0;
      ret_q   <= '0;
      tgt_q   <= '0;
      taken_q <= 1'b0;
    end else if (accept) begin
      op_q    <= br_op_e'(br_op);
      rd_q    <= rd_val[PC_W-1:0];
      ret_q   <= ret_d;
      tgt_q   <= tgt_d;
      taken_q <= taken_d;
    end
  end

  assign pc     = pc_q;
  assign status = status_q;
  assign done   = (state_q == StDone);
  assign taken  = done & taken_q;
  assign lr_we  = done & is_link(op_q);

  always_comb begin
    lr_data = '0;
    if (lr_we) begin
      lr_data[PC_W-1:0] = ret_q;
    end
  end

endmodule

// File: tb/tb_branch_unit.sv
module tb_branch_unit;

  localparam int unsigned PC_W   = 9;
  localparam int unsigned IMM_W  = 8;
  localparam int unsigned DATA_W = 16;

  logic              clk;
  logic              rst_n;
  logic [2:0]        flag_in;
  logic              flag_load;
  logic              pc_inc;
  logic              br_valid;
  logic              br_ready;
  logic [1:0]        br_op;
  logic [2:0]        cond;
  logic [IMM_W-1:0]  offset;
  logic [DATA_W-1:0] rd_val;
  logic [PC_W-1:0]   pc;
  logic [2:0]        status;
  logic              lr_we;
  logic [DATA_W-1:0] lr_data;
  logic              done;
  logic              taken;

  branch_unit #(
    .PC_W     (PC_W),
    .IMM_W    (IMM_W),
    .DATA_W   (DATA_W),
    .RESET_PC (9'd0)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flag_in   (flag_in),
    .flag_load (flag_load),
    .pc_inc    (pc_inc),
    .br_valid  (br_valid),
    .br_ready  (br_ready),
    .br_op     (br_op),
    .cond      (cond),
    .offset    (offset),
    .rd_val    (rd_val),
    .pc        (pc),
    .status    (status),
    .lr_we     (lr_we),
    .lr_data   (lr_data),
    .done      (done),
    .taken     (taken)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [8:0]  pc;
    logic        taken;
    logic        lr_we;
    logic [15:0] lr_data;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  logic [8:0] mpc;
  logic [2:0] mstat;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic cond_model(input logic [2:0] c, input logic [2:0] f);
    logic z, n, v, r;
    z = f[0];
    n = f[1];
    v = f[2];
    case (c)
      3'd0: r = 1'b1;
      3'd1: r = z;
      3'd2: r = !z;
      3'd3: r = n ^ v;
      3'd4: r = (n ^ v) | z;
`ifdef BRANCH_COND_EXT_EN
      3'd5: r = !(n ^ v);
      3'd6: r = !(n ^ v) & !z;
      3'd7: r = n;
`endif
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  // Scoreboard consumer: every DONE cycle must match the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      check("lr_we_outside_done", {31'b0, lr_we & ~done}, 32'd0);
      if (done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", {31'b0, done}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("done_pc", {23'b0, pc}, {23'b0, e.pc});
          check("done_taken", {31'b0, taken}, {31'b0, e.taken});
          check("done_lr_we", {31'b0, lr_we}, {31'b0, e.lr_we});
          check("done_lr_data", {16'b0, lr_data}, {16'b0, e.lr_data});
        end
      end
    end
  end

  task automatic do_inc(input int n);
    for (int i = 0; i < n; i++) begin
      pc_inc = 1'b1;
      @(posedge clk);
      #1;
      mpc = mpc + 9'd1;
    end
    pc_inc = 1'b0;
    check("pc_after_inc", {23'b0, pc}, {23'b0, mpc});
  endtask

  task automatic load_flags(input logic [2:0] f);
    flag_in   = f;
    flag_load = 1'b1;
    @(posedge clk);
    #1;
    flag_load = 1'b0;
    mstat     = f;
    check("status_load", {29'b0, status}, {29'b0, mstat});
  endtask

  task automatic branch(input string tag, input logic [1:0] op, input logic [2:0] c,
                        input logic [7:0] off, input logic [15:0] rd, input logic inc,
                        input logic fl, input logic [2:0] fin);
    exp_t       e;
    logic       tk;
    logic [8:0] ret, tgt, npc;
    tk  = (op != 2'b00) || cond_model(c, mstat);
    ret = mpc + 9'd1;
    tgt = mpc + 9'd1 + {off[7], off};
    npc = !tk ? ret : ((op == 2'b10 || op == 2'b11) ? rd[8:0] : tgt);
    e.pc      = npc;
    e.taken   = tk;
    e.lr_we   = (op == 2'b01 || op == 2'b11);
    e.lr_data = e.lr_we ? {7'b0, ret} : 16'h0000;
    check({tag, "_ready"}, {31'b0, br_ready}, 32'd1);
    br_valid  = 1'b1;
    br_op     = op;
    cond      = c;
    offset    = off;
    rd_val    = rd;
    pc_inc    = inc;
    flag_load = fl;
    flag_in   = fin;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    flag_load = 1'b0;
    if (fl) mstat = fin;
    check({tag, "_busy"}, {31'b0, br_ready}, 32'd0);
    // Keep a different request and pc_inc asserted while busy; both must be ignored.
    br_valid = 1'b1;
    br_op    = 2'b10;
    rd_val   = 16'h0055;
    pc_inc   = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) break;
    end
    br_valid = 1'b0;
    pc_inc   = 1'b0;
    if (exp_q.size() != 0) begin
      check({tag, "_timeout"}, exp_q.size(), 32'd0);
      exp_q.delete();
    end
    mpc = npc;
    check({tag, "_pc_idle"}, {23'b0, pc}, {23'b0, mpc});
  endtask

  initial begin
    rst_n     = 1'b0;
    flag_in   = 3'b000;
    flag_load = 1'b0;
    pc_inc    = 1'b0;
    br_valid  = 1'b0;
    br_op     = 2'b00;
    cond      = 3'b000;
    offset    = 8'h00;
    rd_val    = 16'h0000;
    mpc       = 9'd0;
    mstat     = 3'b000;
    #2;
    check("rst_pc", {23'b0, pc}, 32'd0);
    check("rst_status", {29'b0, status}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_taken", {31'b0, taken}, 32'd0);
    check("rst_lr_we", {31'b0, lr_we}, 32'd0);
    check("rst_lr_data", {16'b0, lr_data}, 32'd0);
    #20;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_ready", {31'b0, br_ready}, 32'd1);

    // Accept wins over a simultaneous pc_inc.
    do_inc(3);
    branch("b_al_with_inc", 2'b00, 3'b000, 8'h02, 16'h0, 1'b1, 1'b0, 3'b0);

    do_inc(4);
    load_flags(3'b001);
    branch("beq_taken", 2'b00, 3'b001, 8'hFD, 16'h0, 1'b0, 1'b0, 3'b0);
    branch("bne_not_taken", 2'b00, 3'b010, 8'h05, 16'h0, 1'b0, 1'b0, 3'b0);

    branch("bx_to_5", 2'b10, 3'b000, 8'h00, 16'h0005, 1'b0, 1'b0, 3'b0);
    branch("bl", 2'b01, 3'b011, 8'h04, 16'h0, 1'b0, 1'b0, 3'b0);

    do_inc(10);
    branch("bx_511", 2'b10, 3'b000, 8'h00, 16'h01FF, 1'b0, 1'b0, 3'b0);
    do_inc(1);

    load_flags(3'b010);
    branch("blt_n", 2'b00, 3'b011, 8'h01, 16'h0, 1'b0, 1'b0, 3'b0);
    load_flags(3'b110);
    branch("blt_nv", 2'b00, 3'b011, 8'h01, 16'h0, 1'b0, 1'b0, 3'b0);
    load_flags(3'b000);
    branch("blt_same_edge_load", 2'b00, 3'b011, 8'h01, 16'h0, 1'b0, 1'b1, 3'b010);
    check("status_after_same_edge", {29'b0, status}, {29'b0, mstat});
    branch("blt_after_load", 2'b00, 3'b011, 8'h01, 16'h0, 1'b0, 1'b0, 3'b0);
    branch("ble_n", 2'b00, 3'b100, 8'h10, 16'h0, 1'b0, 1'b0, 3'b0);
    branch("blx", 2'b11, 3'b000, 8'h00, 16'hFE23, 1'b0, 1'b0, 3'b0);

    load_flags(3'b000);
    branch("cond_110", 2'b00, 3'b110, 8'h03, 16'h0, 1'b0, 1'b0, 3'b0);
    branch("cond_101", 2'b00, 3'b101, 8'h03, 16'h0, 1'b0, 1'b0, 3'b0);
    load_flags(3'b010);
    branch("cond_111", 2'b00, 3'b111, 8'h03, 16'h0, 1'b0, 1'b0, 3'b0);
    branch("b_neg_wrap", 2'b00, 3'b000, 8'h80, 16'h0, 1'b0, 1'b0, 3'b0);

    // Reset during EXEC of a BL aborts it silently.
    do_inc(2);
    br_valid = 1'b1;
    br_op    = 2'b01;
    cond     = 3'b000;
    offset   = 8'h07;
    @(posedge clk);
    #1;
    br_valid = 1'b0;
    check("abort_busy", {31'b0, br_ready}, 32'd0);
    rst_n = 1'b0;
    #1;
    check("abort_pc", {23'b0, pc}, 32'd0);
    check("abort_done", {31'b0, done}, 32'd0);
    check("abort_lr_we", {31'b0, lr_we}, 32'd0);
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    mpc   = 9'd0;
    mstat = 3'b000;
    @(posedge clk);
    #1;
    check("abort_ready", {31'b0, br_ready}, 32'd1);
    check("abort_status", {29'b0, status}, 32'd0);
    repeat (4) @(posedge clk);
    #1;
    check("abort_pc_hold", {23'b0, pc}, 32'd0);
    branch("post_abort_b", 2'b00, 3'b000, 8'h01, 16'h0, 1'b0, 1'b0, 3'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
